// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory port arbiter.
//   arb_state_e : sequencer states (IDLE, BUSY, DONE)
//   owner_e     : which requester holds the memory port
//   SZ_*        : store/load size encoding used by the control unit (s_length)
package mem_arb_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: bundles the fetch, load/store and memory-side signals.
//   modport slave  : the arbiter (takes requests, drives the memory port)
//   modport master : the environment (core requesters plus the memory)
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) ();

    // fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;
    logic              if_err;

    // load/store requester
    logic              lsu_req;
    logic              lsu_wren;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata;
    logic [1:0]        lsu_size;
    logic [DATA_W-1:0] lsu_rdata;
    logic              lsu_ack;
    logic              lsu_err;

    // shared memory port
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [BE_W-1:0]   mem_be;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport slave (
        input  if_req, if_addr,
        output if_rdata, if_ack, if_err,
        input  lsu_req, lsu_wren, lsu_addr, lsu_wdata, lsu_size,
        output lsu_rdata, lsu_ack, lsu_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output if_req, if_addr,
        input  if_rdata, if_ack, if_err,
        output lsu_req, lsu_wren, lsu_addr, lsu_wdata, lsu_size,
        input  lsu_rdata, lsu_ack, lsu_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_lane_align.sv
// mem_lane_align: combinational byte-lane steering for the granted request.
//   addr       in  low two address bits
//   size       in  SZ_BYTE / SZ_HALF / SZ_WORD (2'b11 illegal)
//   wdata      in  right-aligned store data
//   is_fetch   in  1 = instruction fetch (always a full word)
//   be         out byte enables
//   wdata_sh   out store data shifted onto its byte lanes
//   misaligned out access cannot be issued
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]        addr,
    input  logic [1:0]        size,
    input  logic [DATA_W-1:0] wdata,
    input  logic              is_fetch,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] wdata_sh,
    output logic              misaligned
);

    // lane enables and alignment rule per access size
    always_comb begin
        be         = '0;
        wdata_sh   = wdata << {addr, 3'b000};
        misaligned = 1'b0;
        if (is_fetch) begin
            be         = '1;
            wdata_sh   = '0;
            misaligned = (addr != 2'b00);
        end else begin
            case (size)
                SZ_BYTE: be = BE_W'(1) << addr;
                SZ_HALF: begin
                    be         = BE_W'(3) << addr;
                    misaligned = addr[0];
                end
                SZ_WORD: begin
                    be         = '1;
                    misaligned = (addr != 2'b00);
                end
                default: misaligned = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter between fetch and load/store for one
// shared memory port with a req/ack (wait-state tolerant) handshake.
//   clk, rst : clock (rising edge), asynchronous active-high reset
//   bus      : mem_port_arbiter_if.slave (fetch, lsu and memory signals)
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a memory access that
// has waited TIMEOUT cycles without mem_ack (completes with err=1, rdata=0).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 255
`endif
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    arb_state_e        state_q, state_d;
    owner_e            owner_q, owner_d;
    logic              last_lsu_q, last_lsu_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
    logic              if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic              lsu_ack_q, lsu_ack_d, lsu_err_q, lsu_err_d;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

    // grant mux: on a tie the requester not served last wins
    logic              grant_lsu;
    logic [ADDR_W-1:0] sel_addr;
    logic [BE_W-1:0]   al_be;
    logic [DATA_W-1:0] al_wdata;
    logic              al_misaligned;

    assign grant_lsu = bus.lsu_req && (!bus.if_req || !last_lsu_q);
    assign sel_addr  = grant_lsu ? bus.lsu_addr : bus.if_addr;

    mem_lane_align u_align (
        .addr       (sel_addr[1:0]),
        .size       (bus.lsu_size),
        .wdata      (bus.lsu_wdata),
        .is_fetch   (!grant_lsu),
        .be         (al_be),
        .wdata_sh   (al_wdata),
        .misaligned (al_misaligned)
    );

    // completion bookkeeping shared by error, timeout and normal finish
    logic              fin, fin_lsu, fin_err;
    logic [DATA_W-1:0] fin_data;

    // next state and next register values
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_lsu_d  = last_lsu_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        if_rdata_d  = if_rdata_q;
        lsu_rdata_d = lsu_rdata_q;
        if_ack_d    = 1'b0;
        if_err_d    = 1'b0;
        lsu_ack_d   = 1'b0;
        lsu_err_d   = 1'b0;
        fin         = 1'b0;
        fin_lsu     = (owner_q == OWN_LSU);
        fin_err     = 1'b0;
        fin_data    = '0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.lsu_req) begin
                    owner_d     = grant_lsu ? OWN_LSU : OWN_IF;
                    last_lsu_d  = grant_lsu;
                    mem_we_d    = grant_lsu && bus.lsu_wren;
                    mem_addr_d  = {sel_addr[ADDR_W-1:2], 2'b00};
                    mem_be_d    = al_be;
                    mem_wdata_d = al_wdata;
                    if (al_misaligned) begin
                        // rejected without touching memory
                        state_d = DONE;
                        fin     = 1'b1;
                        fin_lsu = grant_lsu;
                        fin_err = 1'b1;
                    end else begin
                        state_d   = BUSY;
                        mem_req_d = 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end
                end
            end
            BUSY: begin
                if (bus.mem_ack) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    fin       = 1'b1;
                    fin_data  = bus.mem_rdata;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d   = DONE;
                    mem_req_d = 1'b0;
                    fin       = 1'b1;
                    fin_err   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (fin) begin
            if (fin_lsu) begin
                lsu_ack_d   = 1'b1;
                lsu_err_d   = fin_err;
                lsu_rdata_d = fin_data;
            end else begin
                if_ack_d    = 1'b1;
                if_err_d    = fin_err;
                if_rdata_d  = fin_data;
            end
        end
    end

    // state and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            last_lsu_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            if_rdata_q  <= '0;
            lsu_rdata_q <= '0;
            if_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            lsu_ack_q   <= 1'b0;
            lsu_err_q   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_lsu_q  <= last_lsu_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            if_rdata_q  <= if_rdata_d;
            lsu_rdata_q <= lsu_rdata_d;
            if_ack_q    <= if_ack_d;
            if_err_q    <= if_err_d;
            lsu_ack_q   <= lsu_ack_d;
            lsu_err_q   <= lsu_err_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_err    = if_err_q;
    assign bus.lsu_rdata = lsu_rdata_q;
    assign bus.lsu_ack   = lsu_ack_q;
    assign bus.lsu_err   = lsu_err_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer sitting between the core's fetch stage, its load/store path and a single shared memory port. Grants one requester at a time with round-robin fairness and drives a wait-state-tolerant req/ack handshake to memory. Converts the control unit's store-size encoding (`s_length`) into byte enables and lane-shifted write data, and rejects misaligned accesses. Its acknowledges are the stall-release signals for the fetch and memory stages.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; fixed at 32 (4 byte lanes).
- `TIMEOUT`, 255, maximum memory wait cycles; used only when `MEM_ARB_TIMEOUT_EN` is defined.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_req`  in  1  fetch request.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  32  fetched word.
- `if_ack`  out  1  one-cycle fetch completion.
- `if_err`  out  1  valid with `if_ack`; misaligned address or timeout.
- `lsu_req`  in  1  data request.
- `lsu_wren`  in  1  1 = store, 0 = load.
- `lsu_addr`  in  ADDR_W  byte address.
- `lsu_wdata`  in  32  store data, right-aligned.
- `lsu_size`  in  2  00 byte, 01 half, 10 word; 11 is illegal and flagged as an error.
- `lsu_rdata`  out  32  raw aligned word. Sign and zero extension happen downstream.
- `lsu_ack`  out  1  one-cycle data completion.
- `lsu_err`  out  1  valid with `lsu_ack`.
- `mem_req`  out  1  memory request, held until `mem_ack`.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  ADDR_W  word address; bits [1:0] are always 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-shifted write data.
- `mem_rdata`  in  32  read data, valid when `mem_ack` is high.
- `mem_ack`  in  1  one-cycle completion from memory. May arrive in the same cycle `mem_req` first rises.

## Operation
- States:
  - IDLE: samples requests.
  - BUSY: memory access outstanding.
  - DONE: acknowledges the requester.
- Request handshake: a requester holds `req` and its payload stable until its ack. Ack is a one-cycle pulse.
- Grant rule in IDLE:
  - Only one of `if_req` / `lsu_req` high: grant it.
  - Both high: grant the one not served last.
  - `last_lsu` resets to 1, so fetch wins the first tie.
- On grant:
  - Latch owner, `mem_we`, `mem_addr`, `mem_be` and `mem_wdata` into registers.
  - Update `last_lsu`.
- Misalignment check at grant:
  - Fetch: `addr[1:0] != 0` is misaligned.
  - Half: `addr[0] = 1` is misaligned.
  - Word: `addr[1:0] != 0` is misaligned.
  - `lsu_size = 11` is misaligned.
  - A misaligned grant goes IDLE -> DONE with err=1, rdata=0 and no `mem_req`.
- Aligned grant: IDLE -> BUSY. In BUSY, `mem_req` = 1 from registered state.
- BUSY -> DONE on `mem_ack`: register `mem_rdata` into the owner's rdata; err=0.
- DONE:
  - Pulse the owner's ack (and err) for exactly one cycle.
  - No grant is made this cycle, even though the requester's `req` is still high.
  - DONE -> IDLE.
- Byte enables:
  - Byte: `be = 0001 << a[1:0]`.
  - Half: `be = 0011 << a[1:0]`.
  - Word: `be = 1111`.
- Write data: `wdata << (8*a[1:0])`.
- Fetch: `mem_we = 0`, `be = 1111`.
- Loads: `mem_we = 0`; `be` is computed as for stores.
- Non-owner outputs: ack and err stay 0; rdata holds its last value.

## Timing
- Reset values:
  - Outputs: all 0, including `if_rdata`, `lsu_rdata` and the `mem_*` outputs.
  - Internal: state IDLE, `last_lsu` = 1, timeout counter 0.
- Reset mid-transaction: `mem_req` drops immediately (asynchronous) and no ack is issued. The memory must tolerate abandoned requests.
- Zero-wait memory: req sampled at cycle 0, `mem_req` in cycle 1, `mem_ack` in cycle 1, ack in cycle 2, next grant possible in cycle 3.
- Throughput: at most one access per 3 cycles; the latency of a request is `3 + wait` cycles.
- Misaligned access: ack in cycle 1 (IDLE -> DONE).
- `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are stable for the whole time `mem_req` is high.

## Configuration
- `MEM_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to BUSY and increments each BUSY cycle without `mem_ack`.
  - When it reaches `TIMEOUT`: drop `mem_req`, go to DONE with err=1 and rdata=0.
  - A `mem_ack` in the same cycle as expiry wins (normal completion).
- `MEM_ARB_TIMEOUT_EN` undefined: no counter; BUSY waits indefinitely.

## Structure
- Package `mem_arb_pkg`:
  - State enum `arb_state_e` (IDLE, BUSY, DONE).
  - Size constants SZ_BYTE, SZ_HALF, SZ_WORD, matching the `s_length` encoding.
  - Owner enum (OWN_IF, OWN_LSU).
- Sub-module `mem_lane_align` (combinational), instantiated at the grant mux:
  - Inputs: addr[1:0], size, wdata, is_fetch.
  - Outputs: be, shifted wdata, misaligned.

## Test plan
- Fetch at 0x100, memory acks after 2 wait cycles with 0xDEADBEEF -> `mem_req` high 3 cycles; `if_ack` pulse; `if_rdata` = 0xDEADBEEF; `if_err` = 0.
- Byte store of 0xAB to 0x203 -> `mem_addr` 0x200, `mem_be` 1000, `mem_wdata[31:24]` = 0xAB, `mem_we` 1.
- Half load at 0x201 -> `lsu_ack` with `lsu_err` one cycle after the grant; `mem_req` never rises.
- `if_req` and `lsu_req` high together from reset -> fetch served first, then lsu. Repeat the tie -> strict alternation.
- With `MEM_ARB_TIMEOUT_EN` and `TIMEOUT` = 4, memory never acks -> `mem_req` drops after 4 BUSY cycles; ack with err=1 and rdata=0.
- `rst` asserted while BUSY -> all outputs 0 that cycle; after release the next request is granted normally.
